// File: rtl/byte_strip.sv
// Transmit-side byte striper: distributes a serial D/DK byte stream round-robin
// over four lanes and presents one complete 4-lane group per transfer.
module byte_strip #(
   parameter logic [7:0] PAD_BYTE = 8'hBC,
   parameter logic       PAD_K    = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] D,
   input  logic       DK,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic       FLUSH,
   output logic [7:0] LANE0,
   output logic [7:0] LANE1,
   output logic [7:0] LANE2,
   output logic [7:0] LANE3,
   output logic       DK_0,
   output logic       DK_1,
   output logic       DK_2,
   output logic       DK_3,
   output logic       LANE_VALID,
   input  logic       LANE_READY,
   output logic [1:0] FILL_CNT
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t     state_r;
   logic [7:0] stg_data_r [4];
   logic [3:0] stg_k_r;
   logic [1:0] fill_r;
   logic [7:0] lane_data_r [4];
   logic [3:0] lane_k_r;
   logic       lane_valid_r;

   logic [7:0] grp_data_s [4];
   logic [3:0] grp_k_s;
   logic       out_free_s;
   logic       stg_full_s;
   logic       accept_s;
   logic       flush_go_s;
   logic       complete_s;

   assign out_free_s = !lane_valid_r || LANE_READY;
   assign stg_full_s = (state_r == ST_HOLD);
   assign IN_READY   = !RESET && !stg_full_s && !FLUSH;
   assign accept_s   = IN_VALID && IN_READY;
   assign flush_go_s = !stg_full_s && FLUSH && (fill_r != 2'd0);
   assign complete_s = flush_go_s || (accept_s && (fill_r == 2'd3));

   assign LANE0      = lane_data_r[0];
   assign LANE1      = lane_data_r[1];
   assign LANE2      = lane_data_r[2];
   assign LANE3      = lane_data_r[3];
   assign DK_0       = lane_k_r[0];
   assign DK_1       = lane_k_r[1];
   assign DK_2       = lane_k_r[2];
   assign DK_3       = lane_k_r[3];
   assign LANE_VALID = lane_valid_r;
   assign FILL_CNT   = fill_r;

   // Assemble the group that completes this cycle: staged slots, the incoming
   // byte in its slot, and pad characters above the fill point on a flush.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         grp_data_s[i] = stg_data_r[i];
         grp_k_s[i]    = stg_k_r[i];
         if (flush_go_s) begin
            if (2'(i) >= fill_r) begin
               grp_data_s[i] = PAD_BYTE;
               grp_k_s[i]    = PAD_K;
            end else begin
               grp_data_s[i] = stg_data_r[i];
               grp_k_s[i]    = stg_k_r[i];
            end
         end else if (2'(i) == fill_r) begin
            grp_data_s[i] = D;
            grp_k_s[i]    = DK;
         end else begin
            grp_data_s[i] = stg_data_r[i];
            grp_k_s[i]    = stg_k_r[i];
         end
      end
   end

   // Fill/hold state machine with staging and the registered output group.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r      <= ST_FILL;
         fill_r       <= 2'd0;
         stg_k_r      <= 4'd0;
         lane_k_r     <= 4'd0;
         lane_valid_r <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            stg_data_r[i]  <= 8'd0;
            lane_data_r[i] <= 8'd0;
         end
      end else begin
         case (state_r)
            ST_FILL: begin
               if (complete_s) begin
                  fill_r <= 2'd0;
                  if (out_free_s) begin
                     lane_valid_r <= 1'b1;
                     lane_k_r     <= grp_k_s;
                     for (int i = 0; i < 4; i++) begin
                        lane_data_r[i] <= grp_data_s[i];
                     end
                  end else begin
                     // Output still occupied: park the whole group in staging.
                     state_r <= ST_HOLD;
                     stg_k_r <= grp_k_s;
                     for (int i = 0; i < 4; i++) begin
                        stg_data_r[i] <= grp_data_s[i];
                     end
                  end
               end else begin
                  if (accept_s) begin
                     stg_data_r[fill_r] <= D;
                     stg_k_r[fill_r]    <= DK;
                     fill_r             <= fill_r + 2'd1;
                  end
                  if (LANE_READY) begin
                     lane_valid_r <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (out_free_s) begin
                  state_r      <= ST_FILL;
                  lane_valid_r <= 1'b1;
                  lane_k_r     <= stg_k_r;
                  for (int i = 0; i < 4; i++) begin
                     lane_data_r[i] <= stg_data_r[i];
                  end
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            default: begin
               state_r <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_strip.sv
// Directed self-checking bench for byte_strip: lane mapping, K flags,
// back-pressure, flush padding, mid-group reset and a continuous stream.
module tb_byte_strip;

   logic       CLK;
   logic       RESET;
   logic [7:0] D;
   logic       DK;
   logic       IN_VALID;
   logic       IN_READY;
   logic       FLUSH;
   logic [7:0] LANE0, LANE1, LANE2, LANE3;
   logic       DK_0, DK_1, DK_2, DK_3;
   logic       LANE_VALID;
   logic       LANE_READY;
   logic [1:0] FILL_CNT;

   int total;
   int bad;

   logic [31:0] lanes_w;
   logic [3:0]  dk_w;
   assign lanes_w = {LANE0, LANE1, LANE2, LANE3};
   assign dk_w    = {DK_0, DK_1, DK_2, DK_3};

   byte_strip dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .D          (D),
      .DK         (DK),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .FLUSH      (FLUSH),
      .LANE0      (LANE0),
      .LANE1      (LANE1),
      .LANE2      (LANE2),
      .LANE3      (LANE3),
      .DK_0       (DK_0),
      .DK_1       (DK_1),
      .DK_2       (DK_2),
      .DK_3       (DK_3),
      .LANE_VALID (LANE_VALID),
      .LANE_READY (LANE_READY),
      .FILL_CNT   (FILL_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic k);
      IN_VALID = 1'b1;
      D        = b;
      DK       = k;
      tick();
   endtask

   task automatic idle();
      IN_VALID = 1'b0;
      D        = 8'h00;
      DK       = 1'b0;
   endtask

   function automatic logic [7:0] stream_byte(input int n);
      return 8'((n * 37) + 1);
   endfunction

   function automatic logic stream_k(input int n);
      return (n % 7) == 0;
   endfunction

   initial begin
      logic [31:0] exp_lanes;
      logic [3:0]  exp_dk;
      total      = 0;
      bad        = 0;
      RESET      = 1'b1;
      FLUSH      = 1'b0;
      LANE_READY = 1'b0;
      idle();
      tick();
      tick();
      check("reset_lanes", lanes_w, 32'h0);
      check("reset_dk", {28'd0, dk_w}, 32'h0);
      check("reset_valid", {31'd0, LANE_VALID}, 32'd0);
      check("reset_fill", {30'd0, FILL_CNT}, 32'd0);
      check("reset_in_ready", {31'd0, IN_READY}, 32'd0);

      // Tests 1+2: one group, K only on the third byte
      RESET      = 1'b0;
      LANE_READY = 1'b1;
      #1;
      check("t1_in_ready", {31'd0, IN_READY}, 32'd1);
      send(8'h11, 1'b0);
      check("t1_fill1", {30'd0, FILL_CNT}, 32'd1);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      check("t1_no_early_valid", {31'd0, LANE_VALID}, 32'd0);
      send(8'h44, 1'b0);
      idle();
      check("t1_valid", {31'd0, LANE_VALID}, 32'd1);
      check("t1_lanes", lanes_w, 32'h11223344);
      check("t2_dk", {28'd0, dk_w}, 32'b0010);
      check("t1_fill0", {30'd0, FILL_CNT}, 32'd0);
      tick();
      check("t1_valid_one_cycle", {31'd0, LANE_VALID}, 32'd0);

      // Test 3: back-pressure with a second group parked in staging
      LANE_READY = 1'b0;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      check("t3_first_valid", {31'd0, LANE_VALID}, 32'd1);
      send(8'h05, 1'b0);
      send(8'h06, 1'b0);
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      check("t3_in_ready_low", {31'd0, IN_READY}, 32'd0);
      check("t3_hold_lanes", lanes_w, 32'h01020304);
      idle();
      tick();
      check("t3_still_held", lanes_w, 32'h01020304);
      check("t3_still_valid", {31'd0, LANE_VALID}, 32'd1);
      check("t3_still_not_ready", {31'd0, IN_READY}, 32'd0);
      LANE_READY = 1'b1;
      tick();
      check("t3_second_lanes", lanes_w, 32'h05060708);
      check("t3_second_valid", {31'd0, LANE_VALID}, 32'd1);
      check("t3_in_ready_back", {31'd0, IN_READY}, 32'd1);
      LANE_READY = 1'b0;
      tick();
      check("t3_stable", lanes_w, 32'h05060708);
      check("t3_stable_valid", {31'd0, LANE_VALID}, 32'd1);
      LANE_READY = 1'b1;
      tick();
      check("t3_drained", {31'd0, LANE_VALID}, 32'd0);

      // Test 4: flush of a partial group, then flush at FILL_CNT=0
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      idle();
      check("t4_fill2", {30'd0, FILL_CNT}, 32'd2);
      FLUSH = 1'b1;
      #1;
      check("t4_flush_blocks_ready", {31'd0, IN_READY}, 32'd0);
      tick();
      check("t4_lanes", lanes_w, 32'hAABBBCBC);
      check("t4_dk", {28'd0, dk_w}, 32'b0011);
      check("t4_valid", {31'd0, LANE_VALID}, 32'd1);
      check("t4_fill0", {30'd0, FILL_CNT}, 32'd0);
      IN_VALID = 1'b1;
      D        = 8'h55;
      tick();
      check("t4_empty_flush_no_valid", {31'd0, LANE_VALID}, 32'd0);
      check("t4_in_valid_ignored", {30'd0, FILL_CNT}, 32'd0);
      tick();
      check("t4_empty_flush_no_valid2", {31'd0, LANE_VALID}, 32'd0);
      FLUSH = 1'b0;
      idle();

      // Test 5: reset mid-group discards held and partial data
      LANE_READY = 1'b0;
      send(8'h71, 1'b1);
      send(8'h72, 1'b0);
      send(8'h73, 1'b0);
      send(8'h74, 1'b0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      idle();
      check("t5_pre_fill", {30'd0, FILL_CNT}, 32'd2);
      check("t5_pre_lanes", lanes_w, 32'h71727374);
      RESET = 1'b1;
      #1;
      check("t5_in_ready_in_reset", {31'd0, IN_READY}, 32'd0);
      tick();
      check("t5_reset_lanes", lanes_w, 32'h0);
      check("t5_reset_dk", {28'd0, dk_w}, 32'h0);
      check("t5_reset_valid", {31'd0, LANE_VALID}, 32'd0);
      check("t5_reset_fill", {30'd0, FILL_CNT}, 32'd0);
      RESET      = 1'b0;
      LANE_READY = 1'b1;
      send(8'hA0, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      idle();
      check("t5_first_group", lanes_w, 32'hA0A1A2A3);
      check("t5_first_valid", {31'd0, LANE_VALID}, 32'd1);
      tick();

      // Test 6: 64-byte continuous stream, reassembled in order
      for (int i = 0; i < 64; i++) begin
         send(stream_byte(i), stream_k(i));
         check("t6_in_ready", {31'd0, IN_READY}, 32'd1);
         if ((i % 4) == 3) begin
            exp_lanes = {stream_byte(i - 3), stream_byte(i - 2), stream_byte(i - 1), stream_byte(i)};
            exp_dk    = {stream_k(i - 3), stream_k(i - 2), stream_k(i - 1), stream_k(i)};
            check("t6_valid", {31'd0, LANE_VALID}, 32'd1);
            check("t6_lanes", lanes_w, exp_lanes);
            check("t6_dk", {28'd0, dk_w}, {28'd0, exp_dk});
         end else begin
            check("t6_gap", {31'd0, LANE_VALID}, 32'd0);
         end
      end
      idle();
      tick();
      check("t6_end_valid", {31'd0, LANE_VALID}, 32'd0);
      check("t6_end_fill", {30'd0, FILL_CNT}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
